blake2b_init: RTL and testbench

- Front-end stage of the BLAKE2b compression core, directly upstream of the round pipeline.
- Accepts one block configuration: chaining value h, byte counter t and final-block flag. Then accepts 16 message words over a valid/ready stream.
- Builds the 16-word working vector v and presents it to the first round stage with round index 0.
- Holds the message block in a register file and serves the round stages' 8-lane message-index lookups until the finalization stage signals the block is done.

---
 rtl/blake2b_init_pkg.sv | 54 +++++
 rtl/blake2b_msg_reg.sv | 34 +++
 rtl/blake2b_init.sv | 97 +++++++++
 tb/tb_blake2b_init.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2b_init_pkg.sv
// Shared widths, BLAKE2b IV constants and the working-vector builder for the compression front end.
// Pure definitions: no latency, no flow control.
`ifndef BLAKE2B_DEFINES_SV
`define BLAKE2B_DEFINES_SV
`define WORD_WIDTH 64
`define WORD_BUS 63:0
`define MINDEX_WIDTH 4
`define MINDEX_BUS 3:0
`define ROUND_INDEX_BUS 3:0
`define BLAKE2B_IV0 64'h6a09e667f3bcc908
`define BLAKE2B_IV1 64'hbb67ae8584caa73b
`define BLAKE2B_IV2 64'h3c6ef372fe94f82b
`define BLAKE2B_IV3 64'ha54ff53a5f1d36f1
`define BLAKE2B_IV4 64'h510e527fade682d1
`define BLAKE2B_IV5 64'h9b05688c2b3e6c1f
`define BLAKE2B_IV6 64'h1f83d9abfb41bd6b
`define BLAKE2B_IV7 64'h5be0cd19137e2179
`endif

package blake2b_init_pkg;

  localparam int WORD_W   = `WORD_WIDTH;
  localparam int MINDEX_W = `MINDEX_WIDTH;

  typedef logic [`WORD_BUS] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_BUSY
  } state_t;

  // v[0..7] = h, v[8..15] = IV with counter and final flag folded into v[12..14]
  function automatic logic [16*WORD_W-1:0] build_v(
    input logic [8*WORD_W-1:0] h,
    input logic [127:0]        t,
    input logic                last
  );
    logic [16*WORD_W-1:0] v;
    v = '0;
    v[8*WORD_W-1:0]    = h;
    v[8*WORD_W  +: 64] = `BLAKE2B_IV0;
    v[9*WORD_W  +: 64] = `BLAKE2B_IV1;
    v[10*WORD_W +: 64] = `BLAKE2B_IV2;
    v[11*WORD_W +: 64] = `BLAKE2B_IV3;
    v[12*WORD_W +: 64] = `BLAKE2B_IV4 ^ t[63:0];
    v[13*WORD_W +: 64] = `BLAKE2B_IV5 ^ t[127:64];
    v[14*WORD_W +: 64] = `BLAKE2B_IV6 ^ {64{last}};
    v[15*WORD_W +: 64] = `BLAKE2B_IV7;
    return v;
  endfunction

endpackage

// File: rtl/blake2b_msg_reg.sv
// 16x64 message register file: one synchronous write port, LANES combinational read ports.
// Reads are zero-latency; writes land on the next clk_i edge. No flow control.
module blake2b_msg_reg
  import blake2b_init_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       we,
  input  logic [3:0]                 addr,
  input  logic [WORD_W-1:0]          data,
  input  logic [LANES*MINDEX_W-1:0]  raddr,
  output logic [LANES*WORD_W-1:0]    rdata
);

  word_t mem [16];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < LANES; j++) begin
      rdata[j*WORD_W +: WORD_W] = mem[raddr[j*MINDEX_W +: MINDEX_W]];
    end
  end

endmodule

// File: rtl/blake2b_init.sv
// Collects h/t/f and 16 message words, emits the initial working vector v one cycle after the
// 16th beat, then serves message lookups until done_i; stalls through cfg_ready_o and m_ready_o.
module blake2b_init
  import blake2b_init_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [8*`WORD_WIDTH-1:0]      h_i,
  input  logic [127:0]                  t_i,
  input  logic                          last_i,
  input  logic                          m_valid_i,
  output logic                          m_ready_o,
  input  logic [`WORD_WIDTH-1:0]        m_data_i,
  output logic                          v_valid_o,
  input  logic                          v_ready_i,
  output logic [16*`WORD_WIDTH-1:0]     v_o,
  output logic [`ROUND_INDEX_BUS]       round_o,
  output logic [8*`WORD_WIDTH-1:0]      h_o,
  input  logic [LANES*`MINDEX_WIDTH-1:0] mindex_bus_i,
  output logic [LANES*`WORD_WIDTH-1:0]  m_bus_o,
  input  logic                          done_i,
  output logic                          busy_o
);

  state_t       state;
  logic [3:0]   beat;
  logic [127:0] t_r;
  logic         last_r;
  logic         m_we;

  // Writes only while loading, so the message stays frozen for the round lookups
  assign m_we = (state == ST_LOAD) && m_valid_i;

  blake2b_msg_reg #(.LANES(LANES)) u_msg_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we      (m_we),
    .addr    (beat),
    .data    (m_data_i),
    .raddr   (mindex_bus_i),
    .rdata   (m_bus_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      beat        <= '0;
      t_r         <= '0;
      last_r      <= 1'b0;
      h_o         <= '0;
      v_o         <= '0;
      round_o     <= '0;
      v_valid_o   <= 1'b0;
      m_ready_o   <= 1'b0;
      busy_o      <= 1'b0;
      cfg_ready_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (cfg_valid_i) begin
          h_o         <= h_i;
          t_r         <= t_i;
          last_r      <= last_i;
          beat        <= '0;
          state       <= ST_LOAD;
          cfg_ready_o <= 1'b0;
          m_ready_o   <= 1'b1;
          busy_o      <= 1'b1;
        end
        ST_LOAD: if (m_valid_i) begin
          beat <= beat + 4'd1;
          if (beat == 4'd15) begin
            v_o       <= build_v(h_o, t_r, last_r);
            round_o   <= '0;
            state     <= ST_EMIT;
            m_ready_o <= 1'b0;
            v_valid_o <= 1'b1;
          end
        end
        ST_EMIT: if (v_ready_i) begin
          v_valid_o <= 1'b0;
          state     <= ST_BUSY;
        end
        ST_BUSY: if (done_i) begin
          state       <= ST_IDLE;
          busy_o      <= 1'b0;
          cfg_ready_o <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2b_init.sv
// Randomised and directed bench for blake2b_init against a word-level model of v and the message block.
module tb_blake2b_init;
  import blake2b_init_pkg::*;

  localparam int LANES = 8;
  localparam logic [63:0] IVC [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  logic                  clk_i = 1'b0;
  logic                  rst_n_i = 1'b0;
  logic                  cfg_valid_i = 1'b0;
  logic                  cfg_ready_o;
  logic [511:0]          h_i = '0;
  logic [127:0]          t_i = '0;
  logic                  last_i = 1'b0;
  logic                  m_valid_i = 1'b0;
  logic                  m_ready_o;
  logic [63:0]           m_data_i = '0;
  logic                  v_valid_o;
  logic                  v_ready_i = 1'b0;
  logic [1023:0]         v_o;
  logic [3:0]            round_o;
  logic [511:0]          h_o;
  logic [LANES*4-1:0]    mindex_bus_i = '0;
  logic [LANES*64-1:0]   m_bus_o;
  logic                  done_i = 1'b0;
  logic                  busy_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0]  blk_h [8];
  logic [63:0]  blk_m [16];
  logic [127:0] blk_t;
  logic         blk_last;

  always #5 clk_i = ~clk_i;

  blake2b_init #(.LANES(LANES)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .h_i(h_i), .t_i(t_i), .last_i(last_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_data_i(m_data_i),
    .v_valid_o(v_valid_o), .v_ready_i(v_ready_i), .v_o(v_o), .round_o(round_o),
    .h_o(h_o), .mindex_bus_i(mindex_bus_i), .m_bus_o(m_bus_o),
    .done_i(done_i), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: working vector word i straight from the BLAKE2b init rules
  function automatic logic [63:0] exp_v_word(input int i);
    if (i < 8)   return blk_h[i];
    if (i < 12)  return IVC[i-8];
    if (i == 12) return IVC[4] ^ blk_t[63:0];
    if (i == 13) return IVC[5] ^ blk_t[127:64];
    if (i == 14) return blk_last ? ~IVC[6] : IVC[6];
    return IVC[7];
  endfunction

  task automatic send_cfg();
    int n = 0;
    while (!cfg_ready_o && n < 50) begin tick(); n++; end
    if (n == 50) check_eq("cfg_ready_timeout", 512'(cfg_ready_o), 512'd1);
    for (int i = 0; i < 8; i++) h_i[i*64 +: 64] = blk_h[i];
    t_i = blk_t;
    last_i = blk_last;
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    check_eq("busy_after_cfg", 512'(busy_o), 512'd1);
    check_eq("cfg_ready_after_cfg", 512'(cfg_ready_o), 512'd0);
  endtask

  task automatic send_msg(input int n, input bit gaps, input bit done_pulse);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        m_valid_i = 1'b0;
        m_data_i = 64'(~i);
        tick();
      end
      check_eq("m_ready_in_load", 512'(m_ready_o), 512'd1);
      if (i == 15) check_eq("v_valid_before_last", 512'(v_valid_o), 512'd0);
      m_valid_i = 1'b1;
      m_data_i = blk_m[i];
      done_i = done_pulse && (i == 5);
      tick();
      m_valid_i = 1'b0;
      done_i = 1'b0;
      if (done_pulse && i == 5) check_eq("done_ignored_in_load", 512'(busy_o), 512'd1);
    end
    if (n == 16) begin
      check_eq("v_valid_after_16th", 512'(v_valid_o), 512'd1);
      check_eq("m_ready_in_emit", 512'(m_ready_o), 512'd0);
    end
  endtask

  task automatic check_v();
    for (int w = 0; w < 16; w++)
      check_eq($sformatf("v%0d", w), 512'(v_o[w*64 +: 64]), 512'(exp_v_word(w)));
    check_eq("round_o", 512'(round_o), 512'd0);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("h_o%0d", i), 512'(h_o[i*64 +: 64]), 512'(blk_h[i]));
  endtask

  task automatic accept_v(input int hold);
    logic [1023:0] snap = v_o;
    v_ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      check_eq("v_valid_hold", 512'(v_valid_o), 512'd1);
      check_eq("v_lo_stable", v_o[511:0], snap[511:0]);
      check_eq("v_hi_stable", v_o[1023:512], snap[1023:512]);
    end
    v_ready_i = 1'b1;
    tick();
    v_ready_i = 1'b0;
    check_eq("v_valid_drop", 512'(v_valid_o), 512'd0);
    check_eq("busy_in_busy", 512'(busy_o), 512'd1);
    tick();
    check_eq("v_valid_stays_low", 512'(v_valid_o), 512'd0);
    check_eq("m_ready_in_busy", 512'(m_ready_o), 512'd0);
  endtask

  task automatic lookup(input logic [3:0] idx [LANES], input logic [LANES*64-1:0] exp, input string tag);
    for (int j = 0; j < LANES; j++) mindex_bus_i[j*4 +: 4] = idx[j];
    #1;
    check_eq(tag, m_bus_o, exp);
  endtask

  task automatic rand_lookup();
    logic [3:0] idx [LANES];
    logic [LANES*64-1:0] exp;
    for (int j = 0; j < LANES; j++) begin
      idx[j] = 4'($urandom_range(0, 15));
      exp[j*64 +: 64] = blk_m[idx[j]];
    end
    lookup(idx, exp, "rand_lookup");
  endtask

  task automatic finish_blk(input bit cfg_in_busy);
    if (cfg_in_busy) begin
      cfg_valid_i = 1'b1;
      tick();
      check_eq("cfg_blocked_busy", 512'(busy_o), 512'd1);
      check_eq("cfg_ready_busy", 512'(cfg_ready_o), 512'd0);
      check_eq("no_reload_busy", 512'(m_ready_o), 512'd0);
    end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    cfg_valid_i = 1'b0;
    check_eq("cfg_ready_after_done", 512'(cfg_ready_o), 512'd1);
    check_eq("busy_after_done", 512'(busy_o), 512'd0);
    check_eq("m_ready_after_done", 512'(m_ready_o), 512'd0);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 8; i++) blk_h[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) blk_m[i] = {$urandom, $urandom};
    blk_t = {$urandom, $urandom, $urandom, $urandom};
    blk_last = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] idx [LANES];
    logic [LANES*64-1:0] exp;
    repeat (3) tick();
    check_eq("rst_cfg_ready", 512'(cfg_ready_o), 512'd1);
    check_eq("rst_v_valid", 512'(v_valid_o), 512'd0);
    check_eq("rst_m_ready", 512'(m_ready_o), 512'd0);
    check_eq("rst_busy", 512'(busy_o), 512'd0);
    check_eq("rst_v_lo", v_o[511:0], 512'd0);
    check_eq("rst_v_hi", v_o[1023:512], 512'd0);
    check_eq("rst_h_o", h_o, 512'd0);
    check_eq("rst_m_bus", m_bus_o, 512'd0);
    rst_n_i = 1'b1;
    tick();
    check_eq("idle_m_ready", 512'(m_ready_o), 512'd0);

    // "abc" single-block vector
    for (int i = 0; i < 8; i++) blk_h[i] = IVC[i];
    blk_h[0] = 64'h6a09e667f2bdc948;
    for (int i = 0; i < 16; i++) blk_m[i] = '0;
    blk_m[0] = 64'h0000000000636261;
    blk_t = 128'd3;
    blk_last = 1'b1;
    send_cfg();
    send_msg(16, 1'b0, 1'b1);
    check_v();
    check_eq("abc_v12", 512'(v_o[12*64 +: 64]), 512'(64'h510e527fade682d2));
    check_eq("abc_v13", 512'(v_o[13*64 +: 64]), 512'(64'h9b05688c2b3e6c1f));
    check_eq("abc_v14", 512'(v_o[14*64 +: 64]), 512'(64'he07c265404be4294));
    accept_v(0);
    finish_blk(1'b0);

    // gapped stream, stalled accept, directed lookups, cfg blocked while busy
    rand_block();
    for (int i = 0; i < 16; i++) blk_m[i] = 64'(1000 + i);
    send_cfg();
    send_msg(16, 1'b1, 1'b0);
    check_v();
    accept_v(5);
    idx = '{4'd14, 4'd10, 4'd4, 4'd8, 4'd9, 4'd15, 4'd13, 4'd6};
    exp = {64'd1006, 64'd1013, 64'd1015, 64'd1009, 64'd1008, 64'd1004, 64'd1010, 64'd1014};
    lookup(idx, exp, "lookup_lanes");
    idx = '{default: 4'd3};
    exp = {LANES{64'd1003}};
    lookup(idx, exp, "lookup_dup3");
    finish_blk(1'b1);

    // asynchronous reset partway through a load
    rand_block();
    send_cfg();
    send_msg(7, 1'b0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("arst_v_valid", 512'(v_valid_o), 512'd0);
    check_eq("arst_busy", 512'(busy_o), 512'd0);
    check_eq("arst_cfg_ready", 512'(cfg_ready_o), 512'd1);
    check_eq("arst_m_ready", 512'(m_ready_o), 512'd0);
    idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    lookup(idx, '0, "arst_m_lo");
    idx = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    lookup(idx, '0, "arst_m_hi");
    #1 rst_n_i = 1'b1;
    tick();

    // counter carry into t1 with last clear
    rand_block();
    blk_t = {64'h1, 64'hffffffffffffffff};
    blk_last = 1'b0;
    send_cfg();
    send_msg(16, 1'b0, 1'b0);
    check_v();
    check_eq("t_v12", 512'(v_o[12*64 +: 64]), 512'(64'h510e527fade682d1 ^ 64'hffffffffffffffff));
    check_eq("t_v13", 512'(v_o[13*64 +: 64]), 512'(64'h9b05688c2b3e6c1e));
    check_eq("t_v14", 512'(v_o[14*64 +: 64]), 512'(64'h1f83d9abfb41bd6b));
    accept_v(1);
    rand_lookup();
    finish_blk(1'b0);

    // randomised blocks
    for (int b = 0; b < 6; b++) begin
      rand_block();
      send_cfg();
      send_msg(16, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_v();
      accept_v(int'($urandom_range(0, 4)));
      for (int k = 0; k < 3; k++) rand_lookup();
      finish_blk(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
